// File: rtl/load_store_unit.sv
// Load/store access engine: one little-endian byte/half/word access at a time,
// read-modify-write for sub-word stores, bounded miss retry. Optional LSU_ALIGN_CHECK_EN.
module load_store_unit #(
   parameter int MAX_RETRY = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] Address,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData,
   input  logic        DMemError
);

   localparam int CNT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
   localparam logic [CNT_W-1:0] LAST_RETRY = CNT_W'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_READ     = 3'd1,
      S_RMW_READ = 3'd2,
      S_WRITE    = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  retry_q, retry_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_error_q, resp_error_d;
   logic              misaligned;

   // Select the addressed lane of a read word and zero/sign extend it.
   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Overlay the right-justified store data onto the read word at its lane.
   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] r;
      r = word;
      case (size)
         2'd0: r[{lane, 3'b000} +: 8] = wd[7:0];
         2'd1: begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned = ((req_size == 2'd1) & req_addr[0]) |
                       (req_size[1] & (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               wdata_d  = req_wdata;
               retry_d  = '0;
               if (misaligned) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_rdata_d = 32'h0000_0000;
               end else if (!req_write) begin
                  state_d = S_READ;
               end else if (req_size[1]) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_RMW_READ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ, S_RMW_READ: begin
            if (DMemError) begin
               if (retry_q == LAST_RETRY) begin
                  // Retries exhausted: report error, never issue the store write.
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_rdata_d = 32'h0000_0000;
               end else begin
                  retry_d = retry_q + CNT_W'(1);
               end
            end else if (state_q == S_READ) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = extract_load(ReadData, addr_q[1:0], size_q, signed_q);
            end else begin
               state_d = S_WRITE;
               wdata_d = merge_store(ReadData, wdata_q, addr_q[1:0], size_q);
            end
         end
         S_WRITE: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0000_0000;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= S_IDLE;
         retry_q      <= '0;
         addr_q       <= 32'h0000_0000;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         wdata_q      <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE) & !Rst;
   assign memRead    = ((state_q == S_READ) | (state_q == S_RMW_READ)) & !Rst;
   assign memWrite   = (state_q == S_WRITE) & !Rst;
   assign Address    = (state_q == S_IDLE) ? 32'h0000_0000 : {addr_q[31:2], 2'b00};
   assign WriteData  = (state_q == S_IDLE) ? 32'h0000_0000 : wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory and miss injection.
module tb_load_store_unit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic        memRead, memWrite;
   logic [31:0] Address, WriteData, ReadData;
   logic        DMemError;

   logic [31:0] mem [0:15];
   int          checks = 0;
   int          failures = 0;

   int          op_lat, op_rd, op_wr;
   logic [31:0] op_wdata, op_addr, op_rdata;
   logic        op_err;

   load_store_unit #(.MAX_RETRY(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .memRead(memRead), .memWrite(memWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
      .DMemError(DMemError)
   );

   always #5 Clk = ~Clk;

   // Memory environment: combinational read, word write at the clock edge.
   assign ReadData = DMemError ? 32'hBAD0_DADA : mem[Address[5:2]];
   always @(posedge Clk) begin
      if (memWrite) mem[Address[5:2]] <= WriteData;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Issue one request and observe until resp_valid; misses<0 means DMemError stuck.
   task automatic run_op(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd, input int misses);
      int miss_left;
      miss_left = misses;
      op_lat = 0; op_rd = 0; op_wr = 0;
      op_wdata = 32'h0; op_addr = 32'h0; op_rdata = 32'h0; op_err = 1'b0;
      check_eq("ready_before_req", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = ad; req_wdata = wd;
      tick();
      req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         DMemError = memRead && (misses < 0 || miss_left > 0);
         #1;
         if (memRead) begin
            op_rd++;
            op_addr = Address;
            if (miss_left > 0) miss_left--;
         end
         if (memWrite) begin
            op_wr++;
            op_wdata = WriteData;
         end
         if (resp_valid) begin
            op_lat = c;
            op_rdata = resp_rdata;
            op_err = resp_error;
            DMemError = 1'b0;
            tick();
            break;
         end
         tick();
      end
      DMemError = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899_AABB;
      Rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; DMemError = 1'b0;
      tick(); tick(); tick();
      check_eq("rst_ready_gated", {31'b0, req_ready}, 32'd0);
      check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check_eq("rst_resp_rdata", resp_rdata, 32'h0);
      check_eq("rst_resp_error", {31'b0, resp_error}, 32'd0);
      check_eq("rst_mem_en", {30'b0, memRead, memWrite}, 32'd0);
      check_eq("rst_address", Address, 32'h0);
      check_eq("rst_wdata", WriteData, 32'h0);
      Rst = 1'b0;
      #1;

      run_op(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0);
      check_eq("lb_s_data", op_rdata, 32'hFFFF_FF99);
      check_eq("lb_s_lat", op_lat, 32'd2);
      check_eq("lb_s_rdcyc", op_rd, 32'd1);
      check_eq("lb_s_addr", op_addr, 32'h10);
      check_eq("ready_after_resp", {31'b0, req_ready}, 32'd1);

      run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
      check_eq("lh_u_data", op_rdata, 32'h0000_8899);
      check_eq("lh_u_lat", op_lat, 32'd2);
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
      check_eq("lw_data", op_rdata, 32'h8899_AABB);
      run_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0);
      check_eq("lb_u_data", op_rdata, 32'h0000_00BB);
      run_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0);
      check_eq("lh_s_data", op_rdata, 32'hFFFF_AABB);

      run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_005A, 0);
      check_eq("sb_rdcyc", op_rd, 32'd1);
      check_eq("sb_wrcyc", op_wr, 32'd1);
      check_eq("sb_wdata", op_wdata, 32'h8899_5ABB);
      check_eq("sb_lat", op_lat, 32'd3);
      check_eq("sb_rdata", op_rdata, 32'h0);
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
      check_eq("sb_readback", op_rdata, 32'h8899_5ABB);

      run_op(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_1234, 0);
      check_eq("sh_wdata", op_wdata, 32'h1234_5ABB);
      run_op(1'b1, 2'd3, 1'b0, 32'h10, 32'h8899_AABB, 0);
      check_eq("sw3_rdcyc", op_rd, 32'd0);
      check_eq("sw3_lat", op_lat, 32'd2);
      check_eq("sw3_wdata", op_wdata, 32'h8899_AABB);

      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3);
      check_eq("miss3_rdcyc", op_rd, 32'd4);
      check_eq("miss3_lat", op_lat, 32'd5);
      check_eq("miss3_data", op_rdata, 32'h8899_AABB);
      check_eq("miss3_err", {31'b0, op_err}, 32'd0);

      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, -1);
      check_eq("stuck_ld_rdcyc", op_rd, 32'd8);
      check_eq("stuck_ld_lat", op_lat, 32'd9);
      check_eq("stuck_ld_err", {31'b0, op_err}, 32'd1);
      check_eq("stuck_ld_data", op_rdata, 32'h0);
      run_op(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_0011, -1);
      check_eq("stuck_sb_wrcyc", op_wr, 32'd0);
      check_eq("stuck_sb_err", {31'b0, op_err}, 32'd1);
      check_eq("stuck_sb_mem", mem[4], 32'h8899_AABB);

      // Reset coincident with WRITE must suppress the commit and the response.
      check_eq("wr_rst_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10;
      req_wdata = 32'hDEAD_BEEF;
      tick();
      req_valid = 1'b0;
      check_eq("wr_rst_in_write", {31'b0, memWrite}, 32'd1);
      Rst = 1'b1;
      #1;
      check_eq("wr_rst_gated", {31'b0, memWrite}, 32'd0);
      tick();
      Rst = 1'b0;
      #1;
      check_eq("wr_rst_idle", {31'b0, req_ready}, 32'd1);
      check_eq("wr_rst_no_resp", {31'b0, resp_valid}, 32'd0);
      tick();
      check_eq("wr_rst_no_resp2", {31'b0, resp_valid}, 32'd0);
      check_eq("wr_rst_mem", mem[4], 32'h8899_AABB);

`ifdef LSU_ALIGN_CHECK_EN
      run_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0);
      check_eq("mis_err", {31'b0, op_err}, 32'd1);
      check_eq("mis_lat", op_lat, 32'd1);
      check_eq("mis_rdcyc", op_rd, 32'd0);
`else
      run_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0);
      check_eq("unal_data", op_rdata, 32'h8899_AABB);
      check_eq("unal_addr", op_addr, 32'h10);
      check_eq("unal_err", {31'b0, op_err}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
